max_pool_3_engine: RTL and testbench

2x2, stride-2 max-pooling engine for the third pooling stage of the CNN accelerator. Reads a channel-major feature map from the upstream conv-3 result BRAM through a read port. Writes the pooled map into the max_pool_3 BRAM through that memory's port A (addr/din/en/we). The classifier stage then reads the pooled map through port B.

---
 rtl/max_pool_3_pkg.sv | 20 ++
 rtl/max_pool_3_addr_gen.sv | 68 ++++++
 rtl/max_pool_3_engine.sv | 144 ++++++++++++++
 tb/tb_max_pool_3_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_3_pkg.sv
// Shared types and constants for the max_pool_3 pooling engine.
package max_pool_3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CMP,
        WRITE,
        DONE
    } state_t;

    localparam int ELEM_W     = 32;
    localparam int ADDR_SHIFT = 2;

    // Pooled dimension for a 2x2 stride-2 window; an odd trailing row/column is dropped.
    function automatic int out_dim(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/max_pool_3_addr_gen.sv
// Output-pixel counters (ox fastest, then oy, then c) and the source/destination
// byte-address generation for the max_pool_3 engine.
module max_pool_3_addr_gen
    import max_pool_3_pkg::*;
#(
    parameter int          IMG_W    = 16,
    parameter int          IMG_H    = 16,
    parameter int          CHANNELS = 32,
    parameter logic [31:0] SRC_BASE = 32'h0,
    parameter logic [31:0] DST_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_adv,
    input  logic [1:0]  i_k,
    output logic [31:0] o_src_addr,
    output logic [31:0] o_dst_addr,
    output logic        o_last
);

    localparam logic [31:0] W  = 32'(IMG_W);
    localparam logic [31:0] H  = 32'(IMG_H);
    localparam logic [31:0] CH = 32'(CHANNELS);
    localparam logic [31:0] OW = 32'(out_dim(IMG_W));
    localparam logic [31:0] OH = 32'(out_dim(IMG_H));

    logic [31:0] r_ox;
    logic [31:0] r_oy;
    logic [31:0] r_c;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic [31:0] w_src_idx;
    logic [31:0] w_dst_idx;

    // Step to the next output pixel; counters are held at zero while the engine idles.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ox <= '0;
            r_oy <= '0;
            r_c  <= '0;
        end else if (i_adv) begin
            if (r_ox == OW - 32'd1) begin
                r_ox <= '0;
                if (r_oy == OH - 32'd1) begin
                    r_oy <= '0;
                    r_c  <= r_c + 32'd1;
                end else begin
                    r_oy <= r_oy + 32'd1;
                end
            end else begin
                r_ox <= r_ox + 32'd1;
            end
        end
    end

    // Window element k: bit 0 selects the right column, bit 1 the lower row.
    always_comb begin
        w_x        = {r_ox[30:0], 1'b0} + {31'b0, i_k[0]};
        w_y        = {r_oy[30:0], 1'b0} + {31'b0, i_k[1]};
        w_src_idx  = (r_c * H + w_y) * W + w_x;
        w_dst_idx  = (r_c * OH + r_oy) * OW + r_ox;
        o_src_addr = SRC_BASE + (w_src_idx << ADDR_SHIFT);
        o_dst_addr = DST_BASE + (w_dst_idx << ADDR_SHIFT);
        o_last     = (r_c == CH - 32'd1) && (r_oy == OH - 32'd1) && (r_ox == OW - 32'd1);
    end

endmodule

// File: rtl/max_pool_3_engine.sv
// 2x2 stride-2 max-pooling engine: reads the conv-3 map, writes the pooled map.
// Optional build macro MAX_POOL_3_RELU_EN fuses a ReLU into the written value.
module max_pool_3_engine
    import max_pool_3_pkg::*;
#(
    parameter int          IMG_W    = 16,
    parameter int          IMG_H    = 16,
    parameter int          CHANNELS = 32,
    parameter logic [31:0] SRC_BASE = 32'h0,
    parameter logic [31:0] DST_BASE = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              src_addr,
    output logic                     src_en,
    input  logic signed [ELEM_W-1:0] src_dout,
    output logic [31:0]              dst_addr,
    output logic [ELEM_W-1:0]        dst_din,
    output logic                     dst_en,
    output logic [3:0]               dst_we
);

    function automatic logic signed [ELEM_W-1:0] smax(input logic signed [ELEM_W-1:0] a,
                                                      input logic signed [ELEM_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    function automatic logic signed [ELEM_W-1:0] relu(input logic signed [ELEM_W-1:0] v);
`ifdef MAX_POOL_3_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    state_t                    r_state;
    logic [1:0]                r_k;
    logic                      r_last;
    logic signed [ELEM_W-1:0]  r_acc;
    logic signed [ELEM_W-1:0]  w_max;
    logic [1:0]                w_k_next;
    logic [31:0]               w_src_addr;
    logic [31:0]               w_dst_addr;
    logic                      w_last;

    assign w_max    = smax(r_acc, src_dout);
    assign w_k_next = (r_state == FETCH) ? r_k + 2'd1 : 2'd0;

    max_pool_3_addr_gen #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .CHANNELS (CHANNELS),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == IDLE),
        .i_adv      (r_state == CMP),
        .i_k        (w_k_next),
        .o_src_addr (w_src_addr),
        .o_dst_addr (w_dst_addr),
        .o_last     (w_last)
    );

    // Control FSM with registered read/write port outputs; the pixel counters
    // advance at the CMP edge, so the WRITE->FETCH edge already sees the next pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            src_en   <= 1'b0;
            src_addr <= '0;
            dst_en   <= 1'b0;
            dst_we   <= 4'h0;
            dst_addr <= '0;
            dst_din  <= '0;
        end else begin
            done   <= 1'b0;
            dst_en <= 1'b0;
            dst_we <= 4'h0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= FETCH;
                        r_k      <= 2'd0;
                        busy     <= 1'b1;
                        src_en   <= 1'b1;
                        src_addr <= w_src_addr;
                    end
                end
                FETCH: begin
                    if (r_k == 2'd3) begin
                        r_state <= CMP;
                        src_en  <= 1'b0;
                    end else begin
                        r_k      <= w_k_next;
                        src_addr <= w_src_addr;
                    end
                end
                CMP: begin
                    r_state  <= WRITE;
                    r_last   <= w_last;
                    dst_en   <= 1'b1;
                    dst_we   <= 4'hF;
                    dst_addr <= w_dst_addr;
                    dst_din  <= relu(w_max);
                end
                WRITE: begin
                    if (r_last) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state  <= FETCH;
                        r_k      <= 2'd0;
                        src_en   <= 1'b1;
                        src_addr <= w_src_addr;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Running window maximum; read k-1 data arrives while FETCH is at step k.
    always_ff @(posedge clk) begin
        if (r_state == FETCH && r_k == 2'd1) begin
            r_acc <= src_dout;
        end else if ((r_state == FETCH && r_k > 2'd1) || r_state == CMP) begin
            r_acc <= w_max;
        end
    end

endmodule

// File: tb/tb_max_pool_3_engine.sv
// Directed bench for max_pool_3_engine: a 4x4x1 instance and a 5x5x2 instance.
module tb_max_pool_3_engine;

`ifdef MAX_POOL_3_RELU_EN
    localparam logic [31:0] NEG_EXP = 32'h0;
`else
    localparam logic [31:0] NEG_EXP = 32'hFFFFFFF9;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a_start, b_start;

    logic               a_busy, a_done, a_src_en, a_dst_en;
    logic [31:0]        a_src_addr, a_dst_addr, a_dst_din;
    logic [3:0]         a_dst_we;
    logic signed [31:0] a_dout;

    logic               b_busy, b_done, b_src_en, b_dst_en;
    logic [31:0]        b_src_addr, b_dst_addr, b_dst_din;
    logic [3:0]         b_dst_we;
    logic signed [31:0] b_dout;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [64];

    int cyc = 0;
    int t0  = 0;
    int n_chk = 0;
    int n_err = 0;

    logic [31:0] a_wa[$], a_wd[$], b_wa[$], b_wd[$];
    int          a_wt[$];
    int a_ndone, a_tdone, a_nbusy, a_nrd, a_badwe;
    int b_ndone, b_tdone, b_nrd, b_badrd;

    max_pool_3_engine #(
        .IMG_W(4), .IMG_H(4), .CHANNELS(1), .SRC_BASE(32'h0), .DST_BASE(32'h0)
    ) u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .src_addr(a_src_addr), .src_en(a_src_en), .src_dout(a_dout),
        .dst_addr(a_dst_addr), .dst_din(a_dst_din), .dst_en(a_dst_en), .dst_we(a_dst_we)
    );

    max_pool_3_engine #(
        .IMG_W(5), .IMG_H(5), .CHANNELS(2), .SRC_BASE(32'h0), .DST_BASE(32'h0)
    ) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .src_addr(b_src_addr), .src_en(b_src_en), .src_dout(b_dout),
        .dst_addr(b_dst_addr), .dst_din(b_dst_din), .dst_en(b_dst_en), .dst_we(b_dst_we)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Source BRAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (a_src_en) a_dout <= mem_a[a_src_addr[5:2]];
        if (b_src_en) b_dout <= mem_b[b_src_addr[7:2]];
    end

    // Port monitors, sampled on the falling edge.
    always @(negedge clk) begin
        int idx;
        if (a_dst_en) begin
            a_wa.push_back(a_dst_addr);
            a_wd.push_back(a_dst_din);
            a_wt.push_back(cyc - t0);
            if (a_dst_we != 4'hF) a_badwe++;
        end else if (a_dst_we != 4'h0) begin
            a_badwe++;
        end
        if (a_done) begin a_ndone++; a_tdone = cyc - t0; end
        if (a_busy) a_nbusy++;
        if (a_src_en) a_nrd++;
        if (b_dst_en) begin
            b_wa.push_back(b_dst_addr);
            b_wd.push_back(b_dst_din);
        end
        if (b_done) begin b_ndone++; b_tdone = cyc - t0; end
        if (b_src_en) begin
            b_nrd++;
            idx = int'(b_src_addr >> 2);
            if ((idx % 5) == 4 || ((idx / 5) % 5) == 4) b_badrd++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_logs();
        a_wa.delete(); a_wd.delete(); a_wt.delete();
        b_wa.delete(); b_wd.delete();
        a_ndone = 0; a_tdone = 0; a_nbusy = 0; a_nrd = 0; a_badwe = 0;
        b_ndone = 0; b_tdone = 0; b_nrd = 0; b_badrd = 0;
    endtask

    // Leaves the caller on the negedge of cycle 1 of the pass.
    task automatic pulse_a();
        @(negedge clk);
        t0 = cyc;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk);
        t0 = cyc;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic check_a4(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] exp_d [4];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        check({tag, "_nwr"}, a_wa.size(), 32'd4);
        for (int i = 0; i < 4 && i < a_wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), a_wa[i], 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), a_wd[i], exp_d[i]);
            check($sformatf("%s_tw%0d", tag, i), a_wt[i], 32'(6 * (i + 1)));
        end
        check({tag, "_ndone"}, a_ndone, 32'd1);
        check({tag, "_tdone"}, a_tdone, 32'd25);
        check({tag, "_nbusy"}, a_nbusy, 32'd25);
        check({tag, "_nrd"}, a_nrd, 32'd16);
        check({tag, "_we"}, a_badwe, 32'd0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) mem_a[i] = 32'(i);
    endtask

    initial begin
        logic [31:0] b_exp [8];
        b_exp = '{32'd6, 32'd8, 32'd16, 32'd18, 32'd31, 32'd33, 32'd41, 32'd43};

        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        load_ramp();
        // 5x5x2 ramp; row 4 and column 4 hold a value larger than anything in-window.
        for (int i = 0; i < 64; i++) begin
            if (i < 50 && ((i % 5) == 4 || ((i / 5) % 5) == 4)) mem_b[i] = 32'd9999;
            else mem_b[i] = 32'(i);
        end
        clr_logs();
        repeat (3) @(negedge clk);

        check("rst_busy", {31'b0, a_busy}, 32'd0);
        check("rst_done", {31'b0, a_done}, 32'd0);
        check("rst_src_en", {31'b0, a_src_en}, 32'd0);
        check("rst_src_addr", a_src_addr, 32'd0);
        check("rst_dst_en", {31'b0, a_dst_en}, 32'd0);
        check("rst_dst_we", {28'b0, a_dst_we}, 32'd0);
        check("rst_dst_addr", a_dst_addr, 32'd0);
        check("rst_dst_din", a_dst_din, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        clr_logs();

        // Ramp 0..15: window maxima are the bottom-right elements.
        pulse_a();
        check("ramp_busy_c1", {31'b0, a_busy}, 32'd1);
        check("ramp_src_en_c1", {31'b0, a_src_en}, 32'd1);
        repeat (30) @(negedge clk);
        check_a4("ramp", 32'd5, 32'd7, 32'd13, 32'd15);
        check("ramp_idle_busy", {31'b0, a_busy}, 32'd0);

        // Signed window in the top-left, -7 elsewhere; extra starts at cycles 3 and 10.
        for (int i = 0; i < 16; i++) mem_a[i] = 32'hFFFFFFF9;
        mem_a[0] = 32'h80000000; mem_a[1] = 32'hFFFFFFFF;
        mem_a[4] = 32'd3;        mem_a[5] = 32'h7FFFFFFF;
        clr_logs();
        pulse_a();
        repeat (2) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (6) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (25) @(negedge clk);
        check_a4("sgn", 32'h7FFFFFFF, NEG_EXP, NEG_EXP, NEG_EXP);

        // Reset at cycle 9 aborts the pass.
        load_ramp();
        clr_logs();
        pulse_a();
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, a_busy}, 32'd0);
        check("abort_src_en", {31'b0, a_src_en}, 32'd0);
        check("abort_src_addr", a_src_addr, 32'd0);
        check("abort_dst_en", {31'b0, a_dst_en}, 32'd0);
        check("abort_dst_din", a_dst_din, 32'd0);
        check("abort_dst_addr", a_dst_addr, 32'd0);
        repeat (30) @(negedge clk);
        check("abort_nwr", a_wa.size(), 32'd1);
        check("abort_ndone", a_ndone, 32'd0);

        // A fresh pass after the abort runs normally.
        clr_logs();
        pulse_a();
        repeat (30) @(negedge clk);
        check_a4("rerun", 32'd5, 32'd7, 32'd13, 32'd15);

        // Odd 5x5 map, two channels.
        clr_logs();
        pulse_b();
        repeat (55) @(negedge clk);
        check("odd_nwr", b_wa.size(), 32'd8);
        for (int i = 0; i < 8 && i < b_wa.size(); i++) begin
            check($sformatf("odd_addr%0d", i), b_wa[i], 32'(4 * i));
            check($sformatf("odd_data%0d", i), b_wd[i], b_exp[i]);
        end
        check("odd_nrd", b_nrd, 32'd32);
        check("odd_edge_reads", b_badrd, 32'd0);
        check("odd_ndone", b_ndone, 32'd1);
        check("odd_tdone", b_tdone, 32'd49);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
